cdb_arbiter: RTL and testbench

Drain end of the per-functional-unit CDB result queues (queue_cdb instances). Each cycle, picks at most one non-empty queue head using round-robin priority, and pops it with a one-cycle deq pulse. The picked entry is registered and broadcast on the common data bus for exactly one cycle, feeding the reservation stations, ROB and register file. Flush discards any pending pick so nothing wrong-path is broadcast after the flush cycle.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_rr_pick.sv | 34 +++
 rtl/cdb_arbiter.sv | 72 +++++++
 tb/tb_cdb_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and helpers for the result-bus drain logic and its round-robin pickers.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_SRC = 4;
    localparam int CDB_TAG_W   = 6;
    localparam int CDB_DATA_W  = 32;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_t;

    // Explicit modulo-n increment so non-power-of-two source counts wrap correctly.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Purely combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int N     = CDB_NUM_SRC,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             any_o
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = int'(ptr_i);
        any_o     = |req_i;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = PTR_W'(idx);
            end
            idx = wrap_inc(idx, N);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Drains the per-unit CDB queues: pops one non-empty head per cycle round-robin and
// broadcasts it on the common data bus one cycle later for exactly one cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  cdb_t               src_data_i  [NUM_SRC],
    input  logic [NUM_SRC-1:0] src_empty_i,
    output logic [NUM_SRC-1:0] src_deq_o,
    output cdb_t               cdb_out_o,
    output logic               cdb_valid_o
);

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    cdb_t               cdb_q, cdb_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               any_grant;

    // Flush and reset both gate eligibility, so no pop ever escapes in those cycles.
    assign elig = ~src_empty_i & {NUM_SRC{~flush_i & ~rst_i}};

    cdb_arbiter_rr_pick #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i     (elig),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_grant)
    );

    assign src_deq_o   = gnt;
    assign cdb_out_o   = cdb_q;
    assign cdb_valid_o = cdb_valid_q;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_d       = '0;
        cdb_valid_d = 1'b0;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (any_grant) begin
            cdb_d       = src_data_i[gnt_idx];
            cdb_d.valid = 1'b1;
            cdb_valid_d = 1'b1;
            rr_ptr_d    = PTR_W'(wrap_inc(int'(gnt_idx), NUM_SRC));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4-source instance for the main sequence and a
// 3-source instance for non-power-of-two wrap.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] srcEmpty;
    cdb_t       srcData [4];
    logic [3:0] srcDeq;
    cdb_t       cdbOut;
    logic       cdbValid;

    logic       flush3;
    logic [2:0] srcEmpty3;
    cdb_t       srcData3 [3];
    logic [2:0] srcDeq3;
    cdb_t       cdbOut3;
    logic       cdbValid3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SRC(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .src_data_i  (srcData),
        .src_empty_i (srcEmpty),
        .src_deq_o   (srcDeq),
        .cdb_out_o   (cdbOut),
        .cdb_valid_o (cdbValid)
    );

    cdb_arbiter #(.NUM_SRC(3)) dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush3),
        .src_data_i  (srcData3),
        .src_empty_i (srcEmpty3),
        .src_deq_o   (srcDeq3),
        .cdb_out_o   (cdbOut3),
        .cdb_valid_o (cdbValid3)
    );

    function automatic cdb_t bcast(input cdb_t e);
        cdb_t r;
        r       = e;
        r.valid = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] empty, input logic fl);
        srcEmpty = empty;
        flush    = fl;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        flush3    = 1'b0;
        srcEmpty  = 4'hF;
        srcEmpty3 = 3'b111;
        for (int i = 0; i < 4; i++) srcData[i] = '{valid: 1'b0, tag: 6'(8 + i), data: 32'hA000_0000 + 32'(i)};
        for (int i = 0; i < 3; i++) srcData3[i] = '{valid: 1'b0, tag: 6'(20 + i), data: 32'hB000_0000 + 32'(i)};

        #3;
        checkOutput("reset_valid", 64'(cdbValid), 64'd0);
        checkOutput("reset_out", 64'(cdbOut), 64'd0);
        checkOutput("reset_deq", 64'(srcDeq), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round robin across all four sources.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'h0, 1'b0);
            checkOutput("rr_deq", 64'(srcDeq), 64'(4'b0001 << (k % 4)));
            nextCycle();
            checkOutput("rr_valid", 64'(cdbValid), 64'd1);
            checkOutput("rr_out", 64'(cdbOut), 64'(bcast(srcData[k % 4])));
        end

        // Reset mid-broadcast clears outputs asynchronously and restarts at source 0.
        applyStimulus(4'h0, 1'b0);
        checkOutput("midrst_pre_deq", 64'(srcDeq), 64'b0001);
        nextCycle();
        checkOutput("midrst_pre_valid", 64'(cdbValid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(cdbValid), 64'd0);
        checkOutput("midrst_out", 64'(cdbOut), 64'd0);
        checkOutput("midrst_deq", 64'(srcDeq), 64'd0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("postrst_deq", 64'(srcDeq), 64'b0001);
        nextCycle();
        checkOutput("postrst_out", 64'(cdbOut), 64'(bcast(srcData[0])));

        // Single source: only source 2 holds tags 5,6,7.
        for (int t = 5; t <= 7; t++) begin
            srcData[2].tag = 6'(t);
            applyStimulus(4'b1011, 1'b0);
            checkOutput("single_deq", 64'(srcDeq), 64'b0100);
            nextCycle();
            checkOutput("single_valid", 64'(cdbValid), 64'd1);
            checkOutput("single_tag", 64'(cdbOut.tag), 64'(t));
        end
        applyStimulus(4'hF, 1'b0);
        checkOutput("idle_deq", 64'(srcDeq), 64'd0);
        nextCycle();
        checkOutput("idle_valid", 64'(cdbValid), 64'd0);
        checkOutput("idle_out", 64'(cdbOut), 64'd0);

        // Pointer sits at 3; only sources 1 and 3 non-empty: grants 3, 1, 3.
        applyStimulus(4'b0101, 1'b0);
        checkOutput("skip_deq0", 64'(srcDeq), 64'b1000);
        nextCycle();
        checkOutput("skip_out0", 64'(cdbOut), 64'(bcast(srcData[3])));
        applyStimulus(4'b0101, 1'b0);
        checkOutput("skip_deq1", 64'(srcDeq), 64'b0010);
        nextCycle();
        checkOutput("skip_out1", 64'(cdbOut), 64'(bcast(srcData[1])));
        applyStimulus(4'b0101, 1'b0);
        checkOutput("skip_deq2", 64'(srcDeq), 64'b1000);
        nextCycle();
        checkOutput("skip_out2", 64'(cdbOut), 64'(bcast(srcData[3])));

        // Flush right after a grant to source 1.
        applyStimulus(4'h0, 1'b0);
        checkOutput("fl_deq0", 64'(srcDeq), 64'b0001);
        nextCycle();
        applyStimulus(4'h0, 1'b0);
        checkOutput("fl_deq1", 64'(srcDeq), 64'b0010);
        nextCycle();
        applyStimulus(4'h0, 1'b1);
        checkOutput("fl_deq_flush", 64'(srcDeq), 64'd0);
        checkOutput("fl_valid_flush", 64'(cdbValid), 64'd1);
        checkOutput("fl_out_flush", 64'(cdbOut), 64'(bcast(srcData[1])));
        nextCycle();
        applyStimulus(4'h0, 1'b0);
        checkOutput("fl_valid_after", 64'(cdbValid), 64'd0);
        checkOutput("fl_out_after", 64'(cdbOut), 64'd0);
        checkOutput("fl_deq_after", 64'(srcDeq), 64'b0001);
        nextCycle();
        checkOutput("fl_out_resume", 64'(cdbOut), 64'(bcast(srcData[0])));
        applyStimulus(4'hF, 1'b0);

        // Three-source instance wraps 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            srcEmpty3 = 3'b000;
            #1;
            checkOutput("n3_deq", 64'(srcDeq3), 64'(3'b001 << (k % 3)));
            nextCycle();
            checkOutput("n3_out", 64'(cdbOut3), 64'(bcast(srcData3[k % 3])));
            checkOutput("n3_ptr", 64'(dut3.rr_ptr_q), 64'((k + 1) % 3));
        end
        srcEmpty3 = 3'b111;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
